// File: rtl/memory_param_rw_pkg.sv
// Shared types and helpers for memory_param_rw: FSM state encoding,
// legal read-latency range and the per-byte even-parity function.
package memory_param_rw_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Even parity: the stored bit makes byte + parity carry an even number of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/memory_param_rw_rd_pipe.sv
// Fixed-latency delay line for read responses (valid/data/err); asynchronous clear on rstn.
// Data and err are zeroed in any stage that does not carry a valid response.
module memory_param_rw_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_err,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_err
);

    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        logic                  r_vld;
        logic [DATA_WIDTH-1:0] r_data;
        logic                  r_err;

        logic                  w_vld_in;
        logic [DATA_WIDTH-1:0] w_data_in;
        logic                  w_err_in;

        if (gi == 0) begin : g_head
            assign w_vld_in  = i_valid;
            assign w_data_in = i_valid ? i_data : '0;
            assign w_err_in  = i_valid & i_err;
        end else begin : g_tail
            assign w_vld_in  = g_stage[gi-1].r_vld;
            assign w_data_in = g_stage[gi-1].r_data;
            assign w_err_in  = g_stage[gi-1].r_err;
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_vld  <= 1'b0;
                r_data <= '0;
                r_err  <= 1'b0;
            end else begin
                r_vld  <= w_vld_in;
                r_data <= w_data_in;
                r_err  <= w_err_in;
            end
        end
    end

    assign o_valid = g_stage[LATENCY-1].r_vld;
    assign o_data  = g_stage[LATENCY-1].r_data;
    assign o_err   = g_stage[LATENCY-1].r_err;

endmodule

// File: rtl/memory_param_rw.sv
// Single-port byte-writable memory with self-initialisation FSM and fixed read latency.
// Optional per-byte parity storage/check when MEMORY_PARAM_RW_PARITY_EN is defined.
module memory_param_rw
    import memory_param_rw_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    init_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX || (DATA_WIDTH % 8) != 0) begin : g_param_check
        $error("memory_param_rw: RD_LATENCY must be 1..4 and DATA_WIDTH a multiple of 8");
    end

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_next;
    logic                  w_accept, w_wr, w_rd;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_rd_err;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
`ifdef MEMORY_PARAM_RW_PARITY_EN
    logic [NB-1:0]         r_par [DEPTH];
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The counter only advances in INIT and wraps to 0 on the last address,
    // so it is already 0 whenever READY is entered.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        req_ready    = 1'b0;
        init_done    = 1'b0;
        case (r_state)
            INIT: begin
                w_cnt_next = r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == ADDR_WIDTH'(DEPTH - 1))
                    w_state_next = READY;
            end
            READY: begin
                req_ready = 1'b1;
                init_done = 1'b1;
                if (clr) begin
                    w_state_next = INIT;
                    w_cnt_next   = '0;
                end
            end
            default: w_state_next = INIT;
        endcase
    end

    assign w_accept = req_valid & req_ready;
    assign w_wr     = w_accept & req_wen;
    assign w_rd     = w_accept & ~req_wen;

    // Array storage is deliberately not reset; INIT clears it after rstn releases.
    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_mem[r_cnt] <= '0;
`ifdef MEMORY_PARAM_RW_PARITY_EN
            r_par[r_cnt] <= '0;
`endif
        end else if (w_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (req_be[b]) begin
                    r_mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
`ifdef MEMORY_PARAM_RW_PARITY_EN
                    r_par[req_addr][b] <= byte_parity(req_wdata[8*b +: 8]);
`endif
                end
            end
        end
    end

    assign w_rd_word = r_mem[req_addr];

`ifdef MEMORY_PARAM_RW_PARITY_EN
    logic [NB-1:0] w_par_calc;
    for (genvar gi = 0; gi < NB; gi++) begin : g_par
        assign w_par_calc[gi] = byte_parity(w_rd_word[8*gi +: 8]);
    end
    assign w_rd_err = |(w_par_calc ^ r_par[req_addr]);
`else
    assign w_rd_err = 1'b0;
`endif

    memory_param_rw_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (RD_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (w_rd),
        .i_data  (w_rd_word),
        .i_err   (w_rd_err),
        .o_valid (rsp_valid),
        .o_data  (rsp_rdata),
        .o_err   (rsp_err)
    );

endmodule
